slider_move_gen: RTL

- Parametrised sliding-piece move generator for the chess accelerator; a generalisation of the single-mode bishop generator.
- Software programs the source board address, destination address, piece coordinates, direction mask and move limit through an Avalon-MM slave, then starts the block.
- Masking the direction set lets one block serve bishop, rook and queen.
- An Avalon-MM master reads the board from SDRAM and writes each legal successor board as a contiguous block of BOARD_DIM*BOARD_DIM bytes.

---
 rtl/slider_move_gen.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/slider_move_gen.sv
// Sliding-piece move generator: loads a board over Avalon-MM, walks the enabled
// ray directions from (x,y) and writes one successor board per legal move.
module slider_move_gen #(
   parameter int BOARD_DIM = 8,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              slave_waitrequest,
   input  logic [3:0]        slave_address,
   input  logic              slave_read,
   output logic [31:0]       slave_readdata,
   input  logic              slave_write,
   input  logic [31:0]       slave_writedata,
   input  logic              master_waitrequest,
   output logic [ADDR_W-1:0] master_address,
   output logic              master_read,
   input  logic [31:0]       master_readdata,
   input  logic              master_readdatavalid,
   output logic              master_write,
   output logic [31:0]       master_writedata
);
   localparam int N  = BOARD_DIM * BOARD_DIM;
   localparam int IW = $clog2(N);
   localparam int LW = IW + 1;
   localparam int PW = (BOARD_DIM > 1) ? $clog2(BOARD_DIM) : 1;
   localparam int SW = PW + 2;
   localparam int CW = $clog2(4 * (BOARD_DIM - 1) + 1) + 1;
   localparam logic signed [SW-1:0] DIM_S    = SW'(BOARD_DIM);
   localparam logic [LW-1:0]        LOAD_END = LW'(N);
   localparam logic [IW-1:0]        LAST_BYTE = IW'(N - 1);

   typedef enum logic [2:0] {IDLE, LOAD, SCAN, EMIT, DONE} state_t;

   state_t                state_q, state_d;
   logic [31:0]           srcBase_q, srcBase_d;
   logic [31:0]           dstBase_q, dstBase_d;
   logic [31:0]           x_q, x_d;
   logic [31:0]           y_q, y_d;
   logic [7:0]            mask_q, mask_d;
   logic [31:0]           limit_q, limit_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  startPending_q, startPending_d;
   logic [LW-1:0]         loadIdx_q, loadIdx_d;
   logic                  loadWait_q, loadWait_d;
   logic [3:0]            dir_q, dir_d;
   logic signed [SW-1:0]  curX_q, curX_d;
   logic signed [SW-1:0]  curY_q, curY_d;
   logic                  endDir_q, endDir_d;
   logic [IW-1:0]         tgtIdx_q, tgtIdx_d;
   logic [IW-1:0]         byteIdx_q, byteIdx_d;
   logic [7:0]            board_q [N];

   logic                  slaveAccept;
   logic                  startReq;
   logic                  onBoardStart;
   logic [IW-1:0]         srcIdx;
   logic [7:0]            movingPiece;
   logic signed [SW-1:0]  startX, startY;
   logic signed [SW-1:0]  dx, dy, tx, ty;
   logic                  offBoard;
   logic [IW-1:0]         tgtIdx;
   logic [7:0]            tgtPiece;
   logic                  blocked;
   logic [CW-1:0]         countInc;
   logic [7:0]            emitByte;
   logic                  unusedRdata;

   assign unusedRdata  = ^master_readdata[31:8];
   assign slaveAccept  = (slave_read || slave_write) && !slave_waitrequest;
   assign startReq     = (slaveAccept && slave_write && slave_address == 4'd0) || startPending_q;
   assign onBoardStart = (x_q < 32'(BOARD_DIM)) && (y_q < 32'(BOARD_DIM));
   assign srcIdx       = IW'(y_q[PW-1:0]) * IW'(BOARD_DIM) + IW'(x_q[PW-1:0]);
   assign movingPiece  = board_q[srcIdx];
   assign startX       = {2'b00, x_q[PW-1:0]};
   assign startY       = {2'b00, y_q[PW-1:0]};
   assign tx           = curX_q + dx;
   assign ty           = curY_q + dy;
   assign offBoard     = tx[SW-1] || ty[SW-1] || (tx >= DIM_S) || (ty >= DIM_S);
   assign tgtIdx       = IW'(ty[PW-1:0]) * IW'(BOARD_DIM) + IW'(tx[PW-1:0]);
   assign tgtPiece     = board_q[tgtIdx];
   assign blocked      = !mask_q[dir_q[2:0]] || offBoard ||
                         ((tgtPiece != 8'd0) && (tgtPiece[7] == movingPiece[7]));
   assign countInc     = count_q + 1'b1;

   // Direction bit order: N, NE, E, SE, S, SW, W, NW (y grows northwards).
   always_comb begin
      dx = '0;
      dy = '0;
      case (dir_q[2:0])
         3'd0: dy = SW'(1);
         3'd1: begin dx = SW'(1);  dy = SW'(1);  end
         3'd2: dx = SW'(1);
         3'd3: begin dx = SW'(1);  dy = SW'(-1); end
         3'd4: dy = SW'(-1);
         3'd5: begin dx = SW'(-1); dy = SW'(-1); end
         3'd6: dx = SW'(-1);
         3'd7: begin dx = SW'(-1); dy = SW'(1);  end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         srcBase_q      <= '0;
         dstBase_q      <= '0;
         x_q            <= '0;
         y_q            <= '0;
         mask_q         <= '0;
         limit_q        <= '0;
         count_q        <= '0;
         startPending_q <= 1'b0;
         loadIdx_q      <= '0;
         loadWait_q     <= 1'b0;
         dir_q          <= '0;
         curX_q         <= '0;
         curY_q         <= '0;
         endDir_q       <= 1'b0;
         tgtIdx_q       <= '0;
         byteIdx_q      <= '0;
      end else begin
         state_q        <= state_d;
         srcBase_q      <= srcBase_d;
         dstBase_q      <= dstBase_d;
         x_q            <= x_d;
         y_q            <= y_d;
         mask_q         <= mask_d;
         limit_q        <= limit_d;
         count_q        <= count_d;
         startPending_q <= startPending_d;
         loadIdx_q      <= loadIdx_d;
         loadWait_q     <= loadWait_d;
         dir_q          <= dir_d;
         curX_q         <= curX_d;
         curY_q         <= curY_d;
         endDir_q       <= endDir_d;
         tgtIdx_q       <= tgtIdx_d;
         byteIdx_q      <= byteIdx_d;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == LOAD && loadWait_q && master_readdatavalid)
         board_q[loadIdx_q[IW-1:0]] <= master_readdata[7:0];
   end

   always_comb begin
      state_d        = state_q;
      srcBase_d      = srcBase_q;
      dstBase_d      = dstBase_q;
      x_d            = x_q;
      y_d            = y_q;
      mask_d         = mask_q;
      limit_d        = limit_q;
      count_d        = count_q;
      startPending_d = startPending_q;
      loadIdx_d      = loadIdx_q;
      loadWait_d     = loadWait_q;
      dir_d          = dir_q;
      curX_d         = curX_q;
      curY_d         = curY_q;
      endDir_d       = endDir_q;
      tgtIdx_d       = tgtIdx_q;
      byteIdx_d      = byteIdx_q;

      // A start accepted in DONE is remembered and launched from IDLE.
      if (slaveAccept && slave_write) begin
         case (slave_address)
            4'd0: if (state_q == DONE) startPending_d = 1'b1;
            4'd1: srcBase_d = slave_writedata;
            4'd2: dstBase_d = slave_writedata;
            4'd3: x_d       = slave_writedata;
            4'd4: y_d       = slave_writedata;
            4'd5: mask_d    = slave_writedata[7:0];
            4'd6: limit_d   = slave_writedata;
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (startReq) begin
               startPending_d = 1'b0;
               count_d        = '0;
               loadIdx_d      = '0;
               loadWait_d     = 1'b0;
               state_d        = onBoardStart ? LOAD : DONE;
            end
         end
         LOAD: begin
            if (loadIdx_q == LOAD_END) begin
               dir_d   = '0;
               curX_d  = startX;
               curY_d  = startY;
               state_d = (movingPiece == 8'd0) ? DONE : SCAN;
            end else if (loadWait_q) begin
               if (master_readdatavalid) begin
                  loadWait_d = 1'b0;
                  loadIdx_d  = loadIdx_q + 1'b1;
               end
            end else if (!master_waitrequest) begin
               loadWait_d = 1'b1;
            end
         end
         SCAN: begin
            if (dir_q == 4'd8) begin
               state_d = DONE;
            end else if (blocked) begin
               dir_d  = dir_q + 1'b1;
               curX_d = startX;
               curY_d = startY;
            end else begin
               curX_d    = tx;
               curY_d    = ty;
               tgtIdx_d  = tgtIdx;
               endDir_d  = (tgtPiece != 8'd0);
               byteIdx_d = '0;
               state_d   = EMIT;
            end
         end
         EMIT: begin
            if (!master_waitrequest) begin
               if (byteIdx_q == LAST_BYTE) begin
                  count_d   = countInc;
                  byteIdx_d = '0;
                  if (endDir_q) begin
                     dir_d  = dir_q + 1'b1;
                     curX_d = startX;
                     curY_d = startY;
                  end
                  state_d = ((limit_q != '0) && ({{(32-CW){1'b0}}, countInc} == limit_q)) ? DONE : SCAN;
               end else begin
                  byteIdx_d = byteIdx_q + 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      slave_waitrequest = (slave_read || slave_write) && (state_q != IDLE) && (state_q != DONE);
      slave_readdata    = '0;
      master_address    = '0;
      master_read       = 1'b0;
      master_write      = 1'b0;
      master_writedata  = '0;
      emitByte          = board_q[byteIdx_q];

      if (slave_read) begin
         case (slave_address)
            4'd0: slave_readdata = {{(32-CW){1'b0}}, count_q};
            4'd1: slave_readdata = srcBase_q;
            4'd2: slave_readdata = dstBase_q;
            4'd3: slave_readdata = x_q;
            4'd4: slave_readdata = y_q;
            4'd5: slave_readdata = {24'd0, mask_q};
            4'd6: slave_readdata = limit_q;
            default: ;
         endcase
      end

      if (byteIdx_q == srcIdx)
         emitByte = 8'd0;
      else if (byteIdx_q == tgtIdx_q)
         emitByte = movingPiece;

      if (state_q == LOAD && !loadWait_q && loadIdx_q != LOAD_END) begin
         master_read    = 1'b1;
         master_address = ADDR_W'(srcBase_q) + ADDR_W'(loadIdx_q);
      end
      if (state_q == EMIT) begin
         master_write     = 1'b1;
         master_address   = ADDR_W'(dstBase_q) + ADDR_W'(count_q) * ADDR_W'(N) + ADDR_W'(byteIdx_q);
         master_writedata = {24'd0, emitByte};
      end
   end
endmodule
